// File: rtl/jr_redirect_ctrl_if.sv
// Bundle of signals between the ID-stage JR redirect controller and the
// surrounding pipeline: decode/forwarding inputs and PC-mux/flush outputs.
interface jr_redirect_ctrl_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic                      id_valid;
  logic                      jr_control;
  logic [REG_ADDR_WIDTH-1:0] rs_addr;
  logic [ADDR_WIDTH-1:0]     rs_data;
  logic                      ex_wr_en;
  logic                      ex_is_load;
  logic [REG_ADDR_WIDTH-1:0] ex_wr_addr;
  logic [ADDR_WIDTH-1:0]     ex_result;
  logic                      mem_wr_en;
  logic [REG_ADDR_WIDTH-1:0] mem_wr_addr;
  logic [ADDR_WIDTH-1:0]     mem_result;
  logic                      stall_if_id;
  logic                      pc_sel;
  logic                      flush_if_id;
  logic [ADDR_WIDTH-1:0]     jr_target;
  logic                      jr_misalign;
  logic [CNT_WIDTH-1:0]      jr_count;

  // Pipeline side: drives decode and forwarding info, consumes redirect.
  modport master (
    output id_valid, jr_control, rs_addr, rs_data,
    output ex_wr_en, ex_is_load, ex_wr_addr, ex_result,
    output mem_wr_en, mem_wr_addr, mem_result,
    input  stall_if_id, pc_sel, flush_if_id, jr_target, jr_misalign, jr_count
  );

  // Controller side.
  modport slave (
    input  id_valid, jr_control, rs_addr, rs_data,
    input  ex_wr_en, ex_is_load, ex_wr_addr, ex_result,
    input  mem_wr_en, mem_wr_addr, mem_result,
    output stall_if_id, pc_sel, flush_if_id, jr_target, jr_misalign, jr_count
  );
endinterface

// File: rtl/jr_redirect_ctrl.sv
// Jump-register redirect controller. Resolves the JR target from the
// register file or the EX/MEM forwarding paths, stalls one cycle on a
// load-use hazard against rs, then redirects the PC and squashes IF/ID.
module jr_redirect_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic               clk,
  input  logic               reset,
  jr_redirect_ctrl_if.slave  jif
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOAD = 2'd1;
  localparam logic [1:0] ST_REDIRECT  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Instruction fetch is word granular; the low two bits are dropped.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    word_align = a & ALIGN_MASK;
  endfunction

  // Counter sticks at all ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    sat_inc = (&c) ? c : c + CNT_ONE;
  endfunction

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic                  rs_nz;
  logic                  ex_match;
  logic                  mem_match;
  logic                  hazard;
  logic                  jr_req;
  logic                  capture;
  logic                  stall_c;
  logic [ADDR_WIDTH-1:0] operand;
  logic                  pc_sel_q;
  logic                  flush_q;
  logic                  misalign_q;
  logic [ADDR_WIDTH-1:0] target_q;
  logic [CNT_WIDTH-1:0]  count_q;

  // Forwarding match and operand selection; r0 is never forwarded.
  always_comb begin
    rs_nz     = |jif.rs_addr;
    ex_match  = jif.ex_wr_en  && (jif.ex_wr_addr  == jif.rs_addr) && rs_nz;
    mem_match = jif.mem_wr_en && (jif.mem_wr_addr == jif.rs_addr) && rs_nz;
    hazard    = ex_match && jif.ex_is_load;
    jr_req    = jif.id_valid && jif.jr_control;
    if (ex_match && !jif.ex_is_load) begin
      operand = jif.ex_result;
    end else if (mem_match) begin
      operand = jif.mem_result;
    end else begin
      operand = jif.rs_data;
    end
  end

  // Next-state, stall and capture decisions; the ID instruction is
  // wrong-path during REDIRECT, so requests there are ignored.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (jr_req) begin
          if (hazard) begin
            stall_c = 1'b1;
            state_d = ST_WAIT_LOAD;
          end else begin
            capture = 1'b1;
            state_d = ST_REDIRECT;
          end
        end
      end
      ST_WAIT_LOAD: begin
        capture = 1'b1;
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered redirect outputs; the count advances together
  // with the redirect so it is visible alongside pc_sel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_sel_q   <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      target_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_sel_q   <= capture;
      flush_q    <= capture;
      misalign_q <= capture && (|operand[1:0]);
      if (capture) begin
        target_q <= word_align(operand);
        count_q  <= sat_inc(count_q);
      end
    end
  end

  assign jif.stall_if_id = stall_c;
  assign jif.pc_sel      = pc_sel_q;
  assign jif.flush_if_id = flush_q;
  assign jif.jr_misalign = misalign_q;
  assign jif.jr_target   = target_q;
  assign jif.jr_count    = count_q;

endmodule

// File: tb/tb_jr_redirect_ctrl.sv
// Directed bench for jr_redirect_ctrl. A second, narrow-counter instance
// shadows the same stimulus so counter saturation is reached quickly.
module tb_jr_redirect_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  jr_redirect_ctrl_if #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) jif ();
  jr_redirect_ctrl_if #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(2))  sif ();

  jr_redirect_ctrl #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .jif   (jif)
  );

  jr_redirect_ctrl #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .jif   (sif)
  );

  assign sif.id_valid    = jif.id_valid;
  assign sif.jr_control  = jif.jr_control;
  assign sif.rs_addr     = jif.rs_addr;
  assign sif.rs_data     = jif.rs_data;
  assign sif.ex_wr_en    = jif.ex_wr_en;
  assign sif.ex_is_load  = jif.ex_is_load;
  assign sif.ex_wr_addr  = jif.ex_wr_addr;
  assign sif.ex_result   = jif.ex_result;
  assign sif.mem_wr_en   = jif.mem_wr_en;
  assign sif.mem_wr_addr = jif.mem_wr_addr;
  assign sif.mem_result  = jif.mem_result;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    jif.id_valid    = 1'b0;
    jif.jr_control  = 1'b0;
    jif.rs_addr     = '0;
    jif.rs_data     = '0;
    jif.ex_wr_en    = 1'b0;
    jif.ex_is_load  = 1'b0;
    jif.ex_wr_addr  = '0;
    jif.ex_result   = '0;
    jif.mem_wr_en   = 1'b0;
    jif.mem_wr_addr = '0;
    jif.mem_result  = '0;
  endtask

  task automatic jr(input logic [4:0] rs, input logic [31:0] data);
    jif.id_valid   = 1'b1;
    jif.jr_control = 1'b1;
    jif.rs_addr    = rs;
    jif.rs_data    = data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc_sel"},   {31'd0, jif.pc_sel},      32'd0);
    chk({tag, "_flush"},    {31'd0, jif.flush_if_id}, 32'd0);
    chk({tag, "_target"},   jif.jr_target,            32'd0);
    chk({tag, "_misalign"}, {31'd0, jif.jr_misalign}, 32'd0);
    chk({tag, "_count"},    {16'd0, jif.jr_count},    32'd0);
    chk({tag, "_stall"},    {31'd0, jif.stall_if_id}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle_inputs();
    do_reset();
    chk_all_zero("rst");

    // Plain JR, no writers in flight
    jr(5'd5, 32'h0000_0040);
    #1;
    chk("plain_stall", {31'd0, jif.stall_if_id}, 32'd0);
    chk("plain_pre_pcsel", {31'd0, jif.pc_sel}, 32'd0);
    step();
    idle_inputs();
    chk("plain_pc_sel", {31'd0, jif.pc_sel}, 32'd1);
    chk("plain_flush", {31'd0, jif.flush_if_id}, 32'd1);
    chk("plain_target", jif.jr_target, 32'h40);
    chk("plain_count", {16'd0, jif.jr_count}, 32'd1);
    chk("plain_misalign", {31'd0, jif.jr_misalign}, 32'd0);
    step();
    chk("plain_pc_sel_drop", {31'd0, jif.pc_sel}, 32'd0);
    chk("plain_flush_drop", {31'd0, jif.flush_if_id}, 32'd0);

    // EX forward beats MEM forward
    jr(5'd5, 32'h0000_0ABC);
    jif.ex_wr_en = 1'b1; jif.ex_is_load = 1'b0; jif.ex_wr_addr = 5'd5; jif.ex_result = 32'h100;
    jif.mem_wr_en = 1'b1; jif.mem_wr_addr = 5'd5; jif.mem_result = 32'h200;
    #1;
    chk("exfwd_stall", {31'd0, jif.stall_if_id}, 32'd0);
    step();
    idle_inputs();
    chk("exfwd_target", jif.jr_target, 32'h100);
    chk("exfwd_count", {16'd0, jif.jr_count}, 32'd2);
    step();

    // MEM forward alone
    jr(5'd9, 32'h0000_0ABC);
    jif.mem_wr_en = 1'b1; jif.mem_wr_addr = 5'd9; jif.mem_result = 32'h204;
    jif.ex_wr_en = 1'b1; jif.ex_wr_addr = 5'd8; jif.ex_result = 32'h999;
    step();
    idle_inputs();
    chk("memfwd_target", jif.jr_target, 32'h204);
    step();

    // Load-use hazard: one stall cycle, then MEM supplies the load data
    jr(5'd5, 32'h0000_0ABC);
    jif.ex_wr_en = 1'b1; jif.ex_is_load = 1'b1; jif.ex_wr_addr = 5'd5; jif.ex_result = 32'h777;
    #1;
    chk("load_stall", {31'd0, jif.stall_if_id}, 32'd1);
    step();
    jif.ex_wr_en = 1'b0; jif.ex_is_load = 1'b0;
    jif.mem_wr_en = 1'b1; jif.mem_wr_addr = 5'd5; jif.mem_result = 32'h80;
    #1;
    chk("load_wait_stall", {31'd0, jif.stall_if_id}, 32'd0);
    chk("load_wait_pc_sel", {31'd0, jif.pc_sel}, 32'd0);
    step();
    idle_inputs();
    chk("load_pc_sel", {31'd0, jif.pc_sel}, 32'd1);
    chk("load_target", jif.jr_target, 32'h80);
    chk("load_count", {16'd0, jif.jr_count}, 32'd4);
    step();

    // Misaligned raw target
    jr(5'd7, 32'h0000_0043);
    step();
    idle_inputs();
    chk("mis_target", jif.jr_target, 32'h40);
    chk("mis_pulse", {31'd0, jif.jr_misalign}, 32'd1);
    step();
    chk("mis_clear", {31'd0, jif.jr_misalign}, 32'd0);

    // r0: EX load writer to r0 neither stalls nor forwards
    jr(5'd0, 32'h0000_0024);
    jif.ex_wr_en = 1'b1; jif.ex_is_load = 1'b1; jif.ex_wr_addr = 5'd0; jif.ex_result = 32'h999;
    jif.mem_wr_en = 1'b1; jif.mem_wr_addr = 5'd0; jif.mem_result = 32'h888;
    #1;
    chk("r0_stall", {31'd0, jif.stall_if_id}, 32'd0);
    step();
    idle_inputs();
    chk("r0_target", jif.jr_target, 32'h24);
    chk("r0_pc_sel", {31'd0, jif.pc_sel}, 32'd1);
    step();

    // Back-to-back: JR during REDIRECT ignored, next cycle accepted
    do_reset();
    jr(5'd3, 32'h10);
    step();
    chk("b2b_first_target", jif.jr_target, 32'h10);
    jif.rs_data = 32'h300;
    step();
    chk("b2b_ignored_pc_sel", {31'd0, jif.pc_sel}, 32'd0);
    chk("b2b_ignored_target", jif.jr_target, 32'h10);
    step();
    idle_inputs();
    chk("b2b_second_pc_sel", {31'd0, jif.pc_sel}, 32'd1);
    chk("b2b_second_target", jif.jr_target, 32'h300);
    chk("b2b_count", {16'd0, jif.jr_count}, 32'd2);
    step();

    // id_valid low: JR decode ignored
    jif.jr_control = 1'b1; jif.rs_addr = 5'd4; jif.rs_data = 32'h500;
    step();
    idle_inputs();
    chk("novalid_pc_sel", {31'd0, jif.pc_sel}, 32'd0);
    chk("novalid_target", jif.jr_target, 32'h300);

    // Reset while waiting on a load drops the pending redirect
    jr(5'd6, 32'h0);
    jif.ex_wr_en = 1'b1; jif.ex_is_load = 1'b1; jif.ex_wr_addr = 5'd6;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("rst_wait");
    step();
    chk("rst_wait_dropped", {31'd0, jif.pc_sel}, 32'd0);

    // Reset during REDIRECT, then IDLE accepts a new JR immediately
    jr(5'd2, 32'h44);
    step();
    idle_inputs();
    chk("rst_redir_pre", {31'd0, jif.pc_sel}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("rst_redir");
    jr(5'd2, 32'h48);
    step();
    idle_inputs();
    chk("rst_redir_idle_pc_sel", {31'd0, jif.pc_sel}, 32'd1);
    chk("rst_redir_idle_target", jif.jr_target, 32'h48);
    step();

    // Saturation: narrow counter sticks at all ones, wide one keeps counting
    for (int i = 0; i < 4; i++) begin
      jr(5'd1, 32'h60 + 32'(i) * 4);
      step();
      idle_inputs();
      step();
    end
    chk("sat_wide_count", {16'd0, jif.jr_count}, 32'd5);
    chk("sat_narrow_count", {30'd0, sif.jr_count}, 32'd3);
    chk("sat_narrow_target", sif.jr_target, 32'h6C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
